// File: rtl/thermal_pkg.sv
// Shared thermal-path types, constants, FSM encoding and the Q7.0 clamp helper
// used by the slope integrator.
package thermal_pkg;

  typedef logic signed [7:0]  temp_q7_t;
  typedef logic signed [15:0] step_t;

  localparam int K_DT_MAX  = 7;
  localparam int HORIZON_W = 4;

  typedef enum logic [1:0] {
    DTI_IDLE    = 2'd0,
    DTI_TRACK   = 2'd1,
    DTI_PREDICT = 2'd2,
    DTI_STALE   = 2'd3
  } dti_state_e;

  typedef struct packed {
    temp_q7_t val;
    logic     sat;
  } clamp_res_t;

  // High bound is applied before the low bound, so an inverted window yields lo.
  function automatic clamp_res_t clamp_q7(input logic signed [16:0] sum17,
                                          input temp_q7_t lo,
                                          input temp_q7_t hi);
    clamp_res_t        r;
    logic signed [16:0] v17;
    logic signed [16:0] lo17;
    logic signed [16:0] hi17;
    lo17  = {{9{lo[7]}}, lo};
    hi17  = {{9{hi[7]}}, hi};
    v17   = sum17;
    r.sat = 1'b0;
    if (v17 > hi17) begin
      v17   = hi17;
      r.sat = 1'b1;
    end
    if (v17 < lo17) begin
      v17   = lo17;
      r.sat = 1'b1;
    end
    r.val = v17[7:0];
    return r;
  endfunction

endpackage

// File: rtl/q7_clamp.sv
// Combinational clamp of a 17-bit signed sum into a Q7.0 window [lo, hi].
module q7_clamp
  import thermal_pkg::*;
(
  input  logic signed [16:0] sum17,
  input  logic signed [7:0]  lo,
  input  logic signed [7:0]  hi,
  output logic signed [7:0]  val,
  output logic               sat
);

  clamp_res_t res;

  assign res = clamp_q7(sum17, lo, hi);
  assign val = res.val;
  assign sat = res.sat;

endmodule

// File: rtl/dt_integrator.sv
// Integrates the scaled Q7.0 slope stream into a reconstructed temperature,
// produces a clamped H-step look-ahead and flags a stalled slope stream.
module dt_integrator
  import thermal_pkg::*;
#(
  parameter int STALE_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [7:0]    T_seed,
  input  logic                 seed,
  input  logic signed [7:0]    dT_in,
  input  logic                 dt_valid,
  input  logic [7:0]           k_dt,
  input  logic [HORIZON_W-1:0] horizon,
  input  logic signed [7:0]    t_lo,
  input  logic signed [7:0]    t_hi,
  output logic signed [7:0]    T_rec,
  output logic                 rec_valid,
  output logic signed [7:0]    T_pred,
  output logic                 pred_valid,
  output logic                 sat,
  output logic                 stale
);

  localparam logic [7:0] STALE_TOP  = 8'(STALE_MAX);
  localparam logic [7:0] STALE_LAST = 8'(STALE_MAX - 1);

  dti_state_e           state_q, state_d;
  temp_q7_t             acc_q, pred_acc_q;
  step_t                last_step_q;
  logic [HORIZON_W-1:0] cnt_q;
  logic [7:0]           stale_cnt_q;

  logic [2:0]         k_eff;
  step_t              step;
  logic signed [16:0] sum17, acc_in17, pred_sum17;
  temp_q7_t           acc_clamped, pred_clamped;
  logic               acc_sat, pred_clamp_unused;

  logic do_seed, do_accept, do_timeout, do_pstep, do_pfire, do_count;

  assign k_eff      = (k_dt > 8'(K_DT_MAX)) ? 3'(K_DT_MAX) : k_dt[2:0];
  assign step       = $signed({{8{dT_in[7]}}, dT_in}) <<< k_eff;
  assign sum17      = {{9{acc_q[7]}}, acc_q} + {step[15], step};
  // The seed value shares the accumulator clamp since both never load together.
  assign acc_in17   = seed ? {{9{T_seed[7]}}, T_seed} : sum17;
  assign pred_sum17 = {{9{pred_acc_q[7]}}, pred_acc_q} + {last_step_q[15], last_step_q};

  q7_clamp u_acc_clamp (
    .sum17 (acc_in17),
    .lo    (t_lo),
    .hi    (t_hi),
    .val   (acc_clamped),
    .sat   (acc_sat)
  );

  q7_clamp u_pred_clamp (
    .sum17 (pred_sum17),
    .lo    (t_lo),
    .hi    (t_hi),
    .val   (pred_clamped),
    .sat   (pred_clamp_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DTI_IDLE;
    else     state_q <= state_d;
  end

  // Priority: seed, then accept, then timeout, then prediction progress.
  always_comb begin
    state_d    = state_q;
    do_seed    = seed;
    do_accept  = 1'b0;
    do_timeout = 1'b0;
    do_pstep   = 1'b0;
    do_pfire   = 1'b0;
    do_count   = 1'b0;
    if (seed) begin
      state_d = DTI_TRACK;
    end else begin
      case (state_q)
        DTI_IDLE: state_d = DTI_IDLE;
        DTI_STALE: begin
          if (dt_valid) begin
            do_accept = 1'b1;
            state_d   = DTI_PREDICT;
          end
        end
        DTI_TRACK, DTI_PREDICT: begin
          if (dt_valid) begin
            do_accept = 1'b1;
            state_d   = DTI_PREDICT;
          end else begin
            do_count = 1'b1;
            if (stale_cnt_q == STALE_LAST) begin
              do_timeout = 1'b1;
              state_d    = DTI_STALE;
            end else if (state_q == DTI_PREDICT) begin
              if (cnt_q != '0) begin
                do_pstep = 1'b1;
              end else begin
                do_pfire = 1'b1;
                state_d  = DTI_TRACK;
              end
            end
          end
        end
        default: state_d = DTI_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      pred_acc_q  <= '0;
      last_step_q <= '0;
      cnt_q       <= '0;
      stale_cnt_q <= '0;
      T_rec       <= '0;
      rec_valid   <= 1'b0;
      T_pred      <= '0;
      pred_valid  <= 1'b0;
      sat         <= 1'b0;
      stale       <= 1'b0;
    end else begin
      pred_valid <= 1'b0;
      if (do_seed) begin
        acc_q       <= acc_clamped;
        T_rec       <= acc_clamped;
        last_step_q <= '0;
        stale_cnt_q <= '0;
        sat         <= 1'b0;
        rec_valid   <= 1'b1;
        stale       <= 1'b0;
      end else if (do_accept) begin
        acc_q       <= acc_clamped;
        T_rec       <= acc_clamped;
        last_step_q <= step;
        sat         <= acc_sat;
        pred_acc_q  <= acc_clamped;
        cnt_q       <= horizon;
        stale_cnt_q <= '0;
        stale       <= 1'b0;
      end else begin
        if (do_count && (stale_cnt_q != STALE_TOP)) stale_cnt_q <= stale_cnt_q + 8'd1;
        if (do_timeout) stale <= 1'b1;
        if (do_pstep) begin
          pred_acc_q <= pred_clamped;
          cnt_q      <= cnt_q - 1'b1;
        end
        if (do_pfire) begin
          T_pred     <= pred_acc_q;
          pred_valid <= 1'b1;
        end
      end
    end
  end

endmodule
